// File: rtl/modaddsub_rr_sched.sv
// Round-robin front end for a shared modular add/sub unit.
// One request is granted at a time; the result returns with its requester id.
module modaddsub_rr_sched #(
  parameter int DATA_WIDTH = 256,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_opA,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_opB,
  input  logic [DATA_WIDTH-1:0]         opM,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DATA_WIDTH-1:0]         res_data,
  output logic [ID_W-1:0]               res_id,
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       idx;
  logic [ID_W-1:0]       gnt_id;
  logic [ID_W-1:0]       id_q;
  logic [NUM_REQ-1:0]    gnt;
  logic                  found;
  logic                  accept;

  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic                  sel_op;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] m_q;
  logic                  op_q;

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   wide;
  logic [DATA_WIDTH-1:0] result;

  // Walk from the slot after the last winner, wrapping at NUM_REQ.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      if (!found && req_valid[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        found    = 1'b1;
      end
    end
  end

  assign req_ready = (state == IDLE && !rst) ? gnt : '0;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a  = req_opA[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b  = req_opB[i*DATA_WIDTH +: DATA_WIDTH];
        sel_op = req_op[i];
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = EXEC;
      EXEC: state_nx = DONE;
      DONE: if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The extra top bit keeps A+B and A+M-B exact before the single fold.
  assign sum = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    wide = '0;
    if (!op_q) begin
      wide = sum;
      if (sum >= {1'b0, m_q}) wide = sum - {1'b0, m_q};
    end else begin
      if (a_q >= b_q) wide = {1'b0, a_q} - {1'b0, b_q};
      else wide = {1'b0, a_q} + {1'b0, m_q} - {1'b0, b_q};
    end
  end

  assign result = wide[DATA_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      busy      <= (state_nx != IDLE);
      res_valid <= (state_nx == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= ID_W'(NUM_REQ - 1);
      id_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      op_q   <= 1'b0;
    end else if (accept) begin
      rr_ptr <= gnt_id;
      id_q   <= gnt_id;
      a_q    <= sel_a;
      b_q    <= sel_b;
      m_q    <= opM;
      op_q   <= sel_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data <= '0;
      res_id   <= '0;
    end else if (state == EXEC) begin
      res_data <= result;
      res_id   <= id_q;
    end
  end

endmodule

// File: tb/tb_modaddsub_rr_sched.sv
// Randomised and directed checks for modaddsub_rr_sched
// against a plain-arithmetic reference.
module tb_modaddsub_rr_sched;

  localparam int W    = 256;
  localparam int NR   = 4;
  localparam int ID_W = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [NR-1:0]        req_op;
  logic [NR*W-1:0]      req_opA;
  logic [NR*W-1:0]      req_opB;
  logic [W-1:0]         opM;
  logic                 res_valid;
  logic                 res_ready;
  logic [W-1:0]         res_data;
  logic [ID_W-1:0]      res_id;
  logic                 busy;

  int tests = 0;
  int fails = 0;

  modaddsub_rr_sched #(.DATA_WIDTH(W), .NUM_REQ(NR), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_opA(req_opA), .req_opB(req_opB),
    .opM(opM),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_mod(
    input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
    input logic [W-1:0] m);
    logic [W+1:0] x;
    if (op) x = ({2'b0, a} + {2'b0, m} - {2'b0, b}) % {2'b0, m};
    else x = ({2'b0, a} + {2'b0, b}) % {2'b0, m};
    return x[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Present a request and return just after its accepting edge.
  task automatic issue(input int i, input bit op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       output bit ok);
    req_op[i]         = op;
    req_opA[i*W +: W] = a;
    req_opB[i*W +: W] = b;
    req_valid[i]      = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      #1;
      if (req_ready[i]) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid[i] = 1'b0;
  endtask

  // Edges counted from and including the accepting edge.
  task automatic wait_res(output logic [W-1:0] d, output logic [ID_W-1:0] id,
                          output int edges);
    edges = 1;
    while (!res_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    d  = res_data;
    id = res_id;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit ok;
    logic [W-1:0] d;
    logic [ID_W-1:0] id;
    int e;
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({res_valid, busy, req_ready} !== '0 || res_data !== '0 || res_id !== '0) begin
      fails++;
      $display("FAIL reset_outputs got v=%0b b=%0b rdy=%b d=%0h id=%0d want all 0",
               res_valid, busy, req_ready, res_data, res_id);
    end
    req_valid = 4'b0001;
    rst = 1'b0;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL reset_first_grant got %b want 0001", req_ready);
    end
    issue(0, 1'b0, 3, 4, ok);
    wait_res(d, id, e);
    tests++;
    if (!ok || d !== 7 || id !== 0 || e !== 2) begin
      fails++;
      $display("FAIL reset_first_op got ok=%0b d=%0d id=%0d e=%0d want 1 7 0 2",
               ok, d, id, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    bit ok;
    logic [W-1:0] d;
    logic [ID_W-1:0] id;
    int e;
    opM = 97;
    issue(2, 1'b0, 90, 20, ok);
    wait_res(d, id, e);
    tests++;
    if (!ok || d !== 13 || id !== 2 || e !== 2) begin
      fails++;
      $display("FAIL add_wrap got ok=%0b d=%0d id=%0d e=%0d want 1 13 2 2",
               ok, d, id, e);
    end
    issue(2, 1'b0, 10, 20, ok);
    wait_res(d, id, e);
    tests++;
    if (!ok || d !== 30 || id !== 2) begin
      fails++;
      $display("FAIL add_nowrap got ok=%0b d=%0d id=%0d want 1 30 2", ok, d, id);
    end
  endtask

  task automatic test_sub();
    bit ok;
    logic [W-1:0] d;
    logic [ID_W-1:0] id;
    int e;
    int av[3] = '{5, 9, 42};
    int bv[3] = '{9, 5, 42};
    int ev[3] = '{93, 4, 0};
    opM = 97;
    for (int t = 0; t < 3; t++) begin
      issue(1, 1'b1, av[t], bv[t], ok);
      wait_res(d, id, e);
      tests++;
      if (!ok || d !== ev[t] || id !== 1 || e !== 2) begin
        fails++;
        $display("FAIL sub_%0d got ok=%0b d=%0d id=%0d e=%0d want %0d id 1",
                 t, ok, d, id, e, ev[t]);
      end
    end
  endtask

  task automatic test_rr();
    int mptr;
    int got;
    int nxt;
    logic [NR-1:0] mask;
    req_opA   = '0;
    req_opB   = '0;
    req_op    = '0;
    res_ready = 1'b1;
    pulse_reset();
    mptr = NR - 1;
    for (int phase = 0; phase < 2; phase++) begin
      mask = (phase == 0) ? 4'b1111 : 4'b1010;
      req_valid = mask;
      got = 0;
      for (int c = 0; c < 40 && got < (phase == 0 ? 6 : 3); c++) begin
        #1;
        if (req_ready != '0) begin
          nxt = -1;
          for (int j = 1; j <= NR && nxt < 0; j++)
            if (mask[(mptr + j) % NR]) nxt = (mptr + j) % NR;
          tests++;
          if (req_ready !== (4'b0001 << nxt)) begin
            fails++;
            $display("FAIL rr_p%0d_n%0d got %b want grant %0d",
                     phase, got, req_ready, nxt);
          end
          mptr = nxt;
          got++;
        end
        @(posedge clk);
        #1;
      end
      tests++;
      if (got != (phase == 0 ? 6 : 3)) begin
        fails++;
        $display("FAIL rr_timeout_p%0d got %0d grants", phase, got);
      end
    end
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [W-1:0] d;
    logic [ID_W-1:0] id;
    int e;
    opM = 97;
    res_ready = 1'b0;
    issue(3, 1'b0, 50, 60, ok);
    wait_res(d, id, e);
    tests++;
    if (!ok || d !== 13 || id !== 3) begin
      fails++;
      $display("FAIL bp_result got ok=%0b d=%0d id=%0d want 1 13 3", ok, d, id);
    end
    req_valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      tests++;
      if (res_valid !== 1'b1 || res_data !== d || res_id !== id ||
          req_ready !== '0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold_%0d got v=%0b d=%0d id=%0d rdy=%b busy=%0b", c,
                 res_valid, res_data, res_id, req_ready, busy);
      end
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL bp_release got v=%0b busy=%0b rdy=%b want 0 0 0001",
               res_valid, busy, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_isolation();
    bit ok;
    logic [W-1:0] d;
    logic [ID_W-1:0] id;
    int e;
    opM = 97;
    issue(1, 1'b0, 90, 20, ok);
    opM = 5;
    req_opA[1*W +: W] = 3;
    wait_res(d, id, e);
    tests++;
    if (!ok || d !== 13 || id !== 1) begin
      fails++;
      $display("FAIL isolation got ok=%0b d=%0d id=%0d want 1 13 1", ok, d, id);
    end
    opM = 97;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    logic [W-1:0] d;
    logic [ID_W-1:0] id;
    int e;
    opM = 97;
    issue(2, 1'b1, 5, 9, ok);
    req_valid = 4'b0001;
    #2 rst = 1'b1;
    #1;
    tests++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
      fails++;
      $display("FAIL rst_exec got v=%0b busy=%0b rdy=%b want 0", res_valid,
               busy, req_ready);
    end
    #2 rst = 1'b0;
    req_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      seen |= res_valid;
    end
    tests++;
    if (seen || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_exec_noresult got seen=%0b busy=%0b want 0 0", seen, busy);
    end
    res_ready = 1'b0;
    issue(3, 1'b0, 1, 2, ok);
    wait_res(d, id, e);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (res_valid !== 1'b0 || res_data !== '0 || res_id !== '0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_done got v=%0b d=%0d id=%0d busy=%0b want 0", res_valid,
               res_data, res_id, busy);
    end
    #2 rst = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    bit ok;
    logic [W-1:0] d;
    logic [W-1:0] m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    logic [ID_W-1:0] id;
    int e;
    int i;
    bit op;
    for (int t = 0; t < 40; t++) begin
      i  = $urandom_range(0, NR - 1);
      op = 1'($urandom_range(0, 1));
      m  = (t % 2 == 0) ? W'($urandom_range(1, 1000)) : rand_w();
      if (m == '0) m = 1;
      a  = rand_w() % m;
      b  = (t % 5 == 0) ? a : rand_w() % m;
      opM = m;
      exp = ref_mod(op, a, b, m);
      issue(i, op, a, b, ok);
      wait_res(d, id, e);
      tests++;
      if (!ok || d !== exp || id !== ID_W'(i) || e !== 2) begin
        fails++;
        $display("FAIL rand_%0d got ok=%0b d=%0h id=%0d e=%0d want %0h id %0d",
                 t, ok, d, id, e, exp, i);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_opA   = '0;
    req_opB   = '0;
    opM       = 97;
    res_ready = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_rr();
    test_backpressure();
    test_isolation();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
